// File: rtl/bcd_time_entry_pkg.sv
// Shared types and constants for the cook-timer keypad entry path.
package bcd_time_entry_pkg;

    localparam int unsigned BCD_W      = 4;
    localparam int unsigned NUM_DIGITS = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        ENTRY,
        LOAD,
        RUN
    } state_e;

    typedef struct packed {
        logic [BCD_W-1:0] min_tens;
        logic [BCD_W-1:0] min_ones;
        logic [BCD_W-1:0] sec_tens;
        logic [BCD_W-1:0] sec_ones;
    } mmss_t;

endpackage

// File: rtl/bcd_digit_shifter.sv
// Four-digit MM:SS BCD entry buffer; new digits enter at seconds-ones and
// push older digits toward minutes-tens.
module bcd_digit_shifter
    import bcd_time_entry_pkg::*;
(
    input  logic             clk,
    input  logic             clrn,
    input  logic             shift_i,
    input  logic             clear_i,
    input  logic [BCD_W-1:0] din_i,
    output mmss_t            buf_o,
    output logic             all_zero_c
);

    mmss_t buf_q, buf_d;

    always_comb begin
        buf_d = buf_q;
        if (clear_i) begin
            buf_d = '0;
        end else if (shift_i) begin
            buf_d.min_tens = buf_q.min_ones;
            buf_d.min_ones = buf_q.sec_tens;
            buf_d.sec_tens = buf_q.sec_ones;
            buf_d.sec_ones = din_i;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            buf_q <= '0;
        end else begin
            buf_q <= buf_d;
        end
    end

    assign buf_o      = buf_q;
    assign all_zero_c = (buf_q == '0);

endmodule

// File: rtl/bcd_time_entry.sv
// Keypad-side writer for the BCD down-counter chain: collects MM:SS digits,
// validates on start, pulses the parallel load, then tracks the run to zero.
module bcd_time_entry
    import bcd_time_entry_pkg::*;
#(
    parameter int unsigned LOAD_CYCLES  = 1,
    parameter int unsigned MAX_SEC_TENS = 5
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             key_valid,
    input  logic [BCD_W-1:0] key_code,
    input  logic             key_clear,
    input  logic             key_start,
    input  logic             timer_zero,
    output logic [BCD_W-1:0] min_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones,
    output logic             loadn,
    output logic             run_en,
    output logic [2:0]       digits,
    output logic             entry_err
);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [2:0] digits_q, digits_d;
    logic       loadn_q, loadn_d;
    logic       run_en_q, run_en_d;
    logic       err_q, err_d;
    logic       shift, clear;
    logic       all_zero;
    mmss_t      buf_val;

    bcd_digit_shifter u_shifter (
        .clk        (clk),
        .clrn       (clrn),
        .shift_i    (shift),
        .clear_i    (clear),
        .din_i      (key_code),
        .buf_o      (buf_val),
        .all_zero_c (all_zero)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            digits_q <= '0;
            loadn_q  <= 1'b1;
            run_en_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            loadn_q  <= loadn_d;
            run_en_q <= run_en_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        digits_d = digits_q;
        loadn_d  = 1'b1;
        run_en_d = 1'b0;
        err_d    = 1'b0;
        shift    = 1'b0;
        clear    = 1'b0;
        case (state_q)
            IDLE, ENTRY: begin
                if (key_clear) begin
                    clear    = 1'b1;
                    digits_d = '0;
                    state_d  = IDLE;
                end else if (key_start) begin
                    if (state_q == IDLE || all_zero ||
                        buf_val.sec_tens > 4'(MAX_SEC_TENS)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = LOAD;
                        loadn_d = 1'b0;
                        cnt_d   = '0;
                    end
                end else if (key_valid) begin
                    if (key_code > BCD_MAX || digits_q == 3'(NUM_DIGITS)) begin
                        err_d = 1'b1;
                    end else begin
                        shift    = 1'b1;
                        digits_d = 3'(digits_q + 3'd1);
                        state_d  = ENTRY;
                    end
                end
            end
            LOAD: begin
                loadn_d = 1'b0;
                if (cnt_q == 3'(LOAD_CYCLES - 1)) begin
                    loadn_d = 1'b1;
                    state_d = RUN;
                end else begin
                    cnt_d = 3'(cnt_q + 3'd1);
                end
            end
            RUN: begin
                run_en_d = 1'b1;
                // Zero flag is only trusted once the chain has counted, masking the pre-load flag.
                if (key_clear || (run_en_q && timer_zero)) begin
                    run_en_d = 1'b0;
                    clear    = 1'b1;
                    digits_d = '0;
                    state_d  = IDLE;
                end else if (key_start) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign min_tens  = buf_val.min_tens;
    assign min_ones  = buf_val.min_ones;
    assign sec_tens  = buf_val.sec_tens;
    assign sec_ones  = buf_val.sec_ones;
    assign loadn     = loadn_q;
    assign run_en    = run_en_q;
    assign digits    = digits_q;
    assign entry_err = err_q;

endmodule

// File: tb/tb_bcd_time_entry.sv
// Directed bench for bcd_time_entry: default instance plus a LOAD_CYCLES=3 instance.
module tb_bcd_time_entry;

    logic       clk = 1'b0;
    logic       clrn;
    logic       key_valid, key_clear, key_start, timer_zero;
    logic [3:0] key_code;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       loadn, run_en, entry_err;
    logic [2:0] digits;

    logic       k3_valid, k3_clear, k3_start, tz3;
    logic [3:0] k3_code;
    logic [3:0] mt3, mo3, st3, so3;
    logic       loadn3, run_en3, err3;
    logic [2:0] digits3;

    logic [15:0] bus, bus3;
    assign bus  = {min_tens, min_ones, sec_tens, sec_ones};
    assign bus3 = {mt3, mo3, st3, so3};

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    bcd_time_entry dut (
        .clk(clk), .clrn(clrn), .key_valid(key_valid), .key_code(key_code),
        .key_clear(key_clear), .key_start(key_start), .timer_zero(timer_zero),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .loadn(loadn), .run_en(run_en), .digits(digits), .entry_err(entry_err)
    );

    bcd_time_entry #(.LOAD_CYCLES(3)) dut3 (
        .clk(clk), .clrn(clrn), .key_valid(k3_valid), .key_code(k3_code),
        .key_clear(k3_clear), .key_start(k3_start), .timer_zero(tz3),
        .min_tens(mt3), .min_ones(mo3), .sec_tens(st3), .sec_ones(so3),
        .loadn(loadn3), .run_en(run_en3), .digits(digits3), .entry_err(err3)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] c);
        key_valid = 1'b1;
        key_code  = c;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic do_start();
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
    endtask

    task automatic do_clear();
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
    endtask

    initial begin
        clrn = 1'b0;
        key_valid = 1'b0; key_clear = 1'b0; key_start = 1'b0; timer_zero = 1'b0; key_code = 4'd0;
        k3_valid = 1'b0; k3_clear = 1'b0; k3_start = 1'b0; tz3 = 1'b0; k3_code = 4'd0;
        repeat (3) tick();
        clrn = 1'b1;
        tick();
        check("rst_bus", bus, 16'h0000);
        check("rst_loadn", 16'(loadn), 16'd1);
        check("rst_run_en", 16'(run_en), 16'd0);
        check("rst_digits", 16'(digits), 16'd0);
        check("rst_err", 16'(entry_err), 16'd0);

        // 01:30 run with a stale zero flag held across the load
        press(4'd1); press(4'd3); press(4'd0);
        check("t1_bus", bus, 16'h0130);
        check("t1_digits", 16'(digits), 16'd3);
        timer_zero = 1'b1;
        do_start();
        check("t1_loadn_low", 16'(loadn), 16'd0);
        check("t1_run_en_load", 16'(run_en), 16'd0);
        check("t1_err", 16'(entry_err), 16'd0);
        tick();
        check("t1_loadn_high", 16'(loadn), 16'd1);
        check("t1_run_en_gap", 16'(run_en), 16'd0);
        tick();
        timer_zero = 1'b0;
        check("t1_run_en_on", 16'(run_en), 16'd1);
        check("t1_bus_hold", bus, 16'h0130);
        repeat (10) tick();
        check("t1_run_en_run", 16'(run_en), 16'd1);
        timer_zero = 1'b1;
        tick();
        timer_zero = 1'b0;
        check("t1_zero_run_en", 16'(run_en), 16'd0);
        check("t1_zero_digits", 16'(digits), 16'd0);
        check("t1_zero_bus", bus, 16'h0000);

        // seconds-tens 9 is rejected
        press(4'd9); press(4'd9);
        check("t2_bus", bus, 16'h0099);
        do_start();
        check("t2_err", 16'(entry_err), 16'd1);
        check("t2_loadn", 16'(loadn), 16'd1);
        tick();
        check("t2_err_single", 16'(entry_err), 16'd0);
        check("t2_loadn_after", 16'(loadn), 16'd1);
        check("t2_bus_kept", bus, 16'h0099);
        do_clear();
        check("t2_clr_bus", bus, 16'h0000);
        check("t2_clr_digits", 16'(digits), 16'd0);
        do_start();
        check("idle_start_err", 16'(entry_err), 16'd1);
        check("idle_start_loadn", 16'(loadn), 16'd1);

        // overflow and illegal code
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        check("t3_bus", bus, 16'h1234);
        check("t3_digits", 16'(digits), 16'd4);
        press(4'd5);
        check("t3_ovf_err", 16'(entry_err), 16'd1);
        check("t3_ovf_bus", bus, 16'h1234);
        check("t3_ovf_digits", 16'(digits), 16'd4);
        do_clear();
        press(4'd7);
        press(4'hB);
        check("t3_bad_err", 16'(entry_err), 16'd1);
        check("t3_bad_bus", bus, 16'h0007);
        check("t3_bad_digits", 16'(digits), 16'd1);

        // clear beats start
        key_clear = 1'b1; key_start = 1'b1;
        tick();
        key_clear = 1'b0; key_start = 1'b0;
        check("t4_bus", bus, 16'h0000);
        check("t4_digits", 16'(digits), 16'd0);
        check("t4_err", 16'(entry_err), 16'd0);
        check("t4_loadn", 16'(loadn), 16'd1);

        // all-zero entry rejected
        press(4'd0);
        check("z_digits", 16'(digits), 16'd1);
        do_start();
        check("z_err", 16'(entry_err), 16'd1);
        check("z_loadn", 16'(loadn), 16'd1);
        do_clear();

        // start and clear while running
        press(4'd4); press(4'd5);
        do_start();
        tick(); tick();
        check("t5_run_en", 16'(run_en), 16'd1);
        do_start();
        check("t5_run_start_err", 16'(entry_err), 16'd1);
        check("t5_run_start_loadn", 16'(loadn), 16'd1);
        check("t5_run_start_run", 16'(run_en), 16'd1);
        do_clear();
        check("t5_abort_run_en", 16'(run_en), 16'd0);
        check("t5_abort_digits", 16'(digits), 16'd0);
        check("t5_abort_bus", bus, 16'h0000);

        // clear and zero together
        press(4'd1);
        do_start();
        tick(); tick();
        key_clear = 1'b1; timer_zero = 1'b1;
        tick();
        key_clear = 1'b0; timer_zero = 1'b0;
        check("t6_run_en", 16'(run_en), 16'd0);
        check("t6_err", 16'(entry_err), 16'd0);
        check("t6_digits", 16'(digits), 16'd0);
        do_start();
        check("t6_idle_loadn", 16'(loadn), 16'd1);

        // three-cycle load; keys during LOAD are ignored
        k3_valid = 1'b1; k3_code = 4'd2;
        tick();
        k3_valid = 1'b0;
        k3_start = 1'b1;
        tick();
        k3_start = 1'b0;
        check("lc3_low1", 16'(loadn3), 16'd0);
        k3_clear = 1'b1;
        tick();
        k3_clear = 1'b0;
        check("lc3_low2", 16'(loadn3), 16'd0);
        check("lc3_bus", bus3, 16'h0002);
        tick();
        check("lc3_low3", 16'(loadn3), 16'd0);
        tick();
        check("lc3_high", 16'(loadn3), 16'd1);
        check("lc3_run_gap", 16'(run_en3), 16'd0);
        tick();
        check("lc3_run_on", 16'(run_en3), 16'd1);
        k3_clear = 1'b1;
        tick();
        k3_clear = 1'b0;
        check("lc3_abort", 16'(run_en3), 16'd0);

        // asynchronous reset in the middle of a load
        k3_valid = 1'b1; k3_code = 4'd2;
        tick();
        k3_valid = 1'b0;
        k3_start = 1'b1;
        tick();
        k3_start = 1'b0;
        check("mid_pre_loadn", 16'(loadn3), 16'd0);
        #2;
        clrn = 1'b0;
        #1;
        check("mid_rst_loadn", 16'(loadn3), 16'd1);
        check("mid_rst_digits", 16'(digits3), 16'd0);
        check("mid_rst_bus", bus3, 16'h0000);
        check("mid_rst_run_en", 16'(run_en3), 16'd0);
        tick();
        clrn = 1'b1;
        tick();
        check("post_rst_loadn", 16'(loadn3), 16'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
